// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer controller.
//   - RAM geometry (index, tag and entry widths)
//   - Bit positions inside a RAM entry and inside a fetch PC
//   - Controller state encoding
//   - Helpers that split a PC into index/tag and build a RAM entry
package btb_pkg;

    localparam int IDX_W   = 7;
    localparam int TAG_W   = 5;
    localparam int ENTRY_W = 36;

    // Entry layout: {valid, tag, target[31:2]}
    localparam int ENT_VALID   = 35;
    localparam int ENT_TAG_MSB = 34;
    localparam int ENT_TAG_LSB = 30;
    localparam int ENT_TGT_MSB = 29;
    localparam int ENT_TGT_LSB = 0;

    // PC fields: index = pc[8:2], tag = pc[13:9]
    localparam int PC_IDX_LSB = 2;
    localparam int PC_TAG_LSB = PC_IDX_LSB + IDX_W;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    function automatic logic [IDX_W-1:0] btb_idx(input logic [31:0] pc);
        return pc[PC_IDX_LSB +: IDX_W];
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(input logic [31:0] pc);
        return pc[PC_TAG_LSB +: TAG_W];
    endfunction

    function automatic logic [ENTRY_W-1:0] btb_entry(input logic        taken,
                                                     input logic [31:0] pc,
                                                     input logic [31:0] target);
        logic [ENTRY_W-1:0] e;
        e                            = '0;
        e[ENT_VALID]                 = taken;
        e[ENT_TAG_MSB:ENT_TAG_LSB]   = btb_tag(pc);
        e[ENT_TGT_MSB:ENT_TGT_LSB]   = target[31:2];
        return e;
    endfunction

endpackage

// File: rtl/btb_ctrl.sv
// Sequencing controller for the 128 x 36 branch target buffer RAM.
// Serves fetch lookups (one per cycle, response next cycle), accepts execute
// updates onto the RAM write port, and runs a full invalidation sweep after
// reset and on every flush request.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lk_valid, lk_pc     lookup request from fetch
//   rsp_valid/hit/target lookup response, one cycle after the request
//   upd_valid/ready     update handshake from execute
//   upd_pc/target/taken update contents (taken=0 invalidates the entry)
//   flush_req           one-cycle pulse, starts (or restarts) a sweep
//   flush_busy          sweep in progress
//   flush_done          one-cycle pulse after the last sweep write
//   ram_a/d/we          RAM write port
//   ram_dpra            RAM read address (combinational from lk_pc)
//   ram_rst_n           clears the RAM output register
//   ram_dpo             RAM registered read data
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_SWEEP | writing zero to entry cnt_q, 0..127; updates stalled
// ST_IDLE  | normal operation; updates accepted unless flush_req
module btb_ctrl
    import btb_pkg::state_e, btb_pkg::ST_SWEEP, btb_pkg::ST_IDLE,
           btb_pkg::btb_idx, btb_pkg::btb_tag, btb_pkg::btb_entry,
           btb_pkg::ENT_VALID, btb_pkg::ENT_TAG_MSB, btb_pkg::ENT_TAG_LSB,
           btb_pkg::ENT_TGT_MSB, btb_pkg::ENT_TGT_LSB;
#(
    parameter int IDX_W   = btb_pkg::IDX_W,
    parameter int TAG_W   = btb_pkg::TAG_W,
    parameter int ENTRY_W = btb_pkg::ENTRY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lk_valid,
    input  logic [31:0]        lk_pc,
    output logic               rsp_valid,
    output logic               rsp_hit,
    output logic [31:0]        rsp_target,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [31:0]        upd_pc,
    input  logic [31:0]        upd_target,
    input  logic               upd_taken,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done,
    output logic [IDX_W-1:0]   ram_a,
    output logic [ENTRY_W-1:0] ram_d,
    output logic               ram_we,
    output logic [IDX_W-1:0]   ram_dpra,
    output logic               ram_rst_n,
    input  logic [ENTRY_W-1:0] ram_dpo
);

    localparam logic [IDX_W-1:0] CNT_LAST = '1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               rsp_valid_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic               rsp_mask_q;

    // ------------------------------------------------------------------
    // Sweep / update sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        upd_ready = 1'b0;
        ram_we    = 1'b0;
        ram_a     = cnt_q;
        ram_d     = '0;

        unique case (state_q)
            ST_SWEEP: begin
                // Reset parks the FSM here; writing must wait until rst drops.
                ram_we = ~rst;
                if (flush_req) begin
                    // Restart: the pulse belongs to the restarted sweep only.
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_IDLE: begin
                // A flush in the same cycle wins over a pending update.
                upd_ready = ~flush_req;
                if (flush_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else if (upd_valid) begin
                    ram_we = 1'b1;
                    ram_a  = btb_idx(upd_pc);
                    ram_d  = btb_entry(upd_taken, upd_pc, upd_target);
                end
            end

            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    assign flush_busy = (state_q == ST_SWEEP);
    assign flush_done = done_q;
    assign ram_rst_n  = ~rst;

    // ------------------------------------------------------------------
    // Lookup pipeline: address goes straight to the RAM, the tag and a
    // "read during sweep" mask travel alongside the registered read data.
    // ------------------------------------------------------------------
    assign ram_dpra = btb_idx(lk_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_mask_q  <= 1'b0;
        end else begin
            rsp_valid_q <= lk_valid;
            rsp_tag_q   <= btb_tag(lk_pc);
            rsp_mask_q  <= (state_q == ST_SWEEP);
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_valid_q & ram_dpo[ENT_VALID]
                      & (ram_dpo[ENT_TAG_MSB:ENT_TAG_LSB] == rsp_tag_q)
                      & ~rsp_mask_q;
    assign rsp_target = {ram_dpo[ENT_TGT_MSB:ENT_TGT_LSB], 2'b00};

    // PC bits outside the index/tag fields and the target's byte offset
    // carry no information for the BTB.
    logic unused_bits;
    assign unused_bits = ^{lk_pc[31:14], lk_pc[1:0], upd_pc[31:14], upd_pc[1:0],
                           upd_target[1:0]};

endmodule
